// File: rtl/food_gen_param.sv
// Food placer for the snake game: folds LFSR draws into a GRID_W x GRID_H field
// and confirms each candidate against snake occupancy, retrying on collision.
module food_gen_param #(
  parameter int                GRID_W    = 30,
  parameter int                GRID_H    = 22,
  parameter int                COORD_W   = 5,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'('hACE1),
  parameter int                MAX_RETRY = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         game_state,
  input  logic               get_food,
  output logic               occ_req,
  output logic [COORD_W-1:0] occ_x,
  output logic [COORD_W-1:0] occ_y,
  input  logic               occ_ack,
  input  logic               occ_hit,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               busy,
  output logic               place_fail
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GEN = 2'd1, S_REQ = 2'd2} state_t;

  localparam logic [1:0] GS_PLAY  = 2'b00;
  localparam logic [1:0] GS_PAUSE = 2'b01;
  localparam logic [1:0] GS_INIT  = 2'b10;
  localparam logic [1:0] GS_OVER  = 2'b11;

  // Right-shifting Galois masks for maximal-length sequences.
  function automatic logic [31:0] galois_taps(input int w);
    case (w)
      10:      galois_taps = 32'h0000_0240;
      11:      galois_taps = 32'h0000_0500;
      15:      galois_taps = 32'h0000_6000;
      16:      galois_taps = 32'h0000_B400;
      17:      galois_taps = 32'h0001_2000;
      18:      galois_taps = 32'h0002_0400;
      20:      galois_taps = 32'h0009_0000;
      21:      galois_taps = 32'h0014_0000;
      22:      galois_taps = 32'h0030_0000;
      23:      galois_taps = 32'h0042_0000;
      25:      galois_taps = 32'h0120_0000;
      28:      galois_taps = 32'h0900_0000;
      31:      galois_taps = 32'h4800_0000;
      32:      galois_taps = 32'h8020_0003;
      default: galois_taps = 32'h0000_B400;
    endcase
  endfunction

  localparam logic [31:0]        TAPS_ALL = galois_taps(LFSR_W);
  localparam logic [LFSR_W-1:0]  TAPS     = TAPS_ALL[LFSR_W-1:0];
  localparam logic [COORD_W-1:0] GW       = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] GH       = COORD_W'(GRID_H);
  localparam logic [7:0]         LAST_TRY = 8'(MAX_RETRY - 1);

  state_t             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [COORD_W-1:0] occ_x_q, occ_x_d, occ_y_q, occ_y_d;
  logic [COORD_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
  logic               food_valid_q, food_valid_d;
  logic               busy_q, busy_d;
  logic               place_fail_q, place_fail_d;
  logic [7:0]         retry_q, retry_d;

  logic [COORD_W-1:0] rx, ry, cand_x, cand_y;
  logic               trigger;

  // One conditional subtract is a full modulo because GRID >= 2^(COORD_W-1).
  assign rx      = lfsr_q[COORD_W-1:0];
  assign ry      = lfsr_q[2*COORD_W-1:COORD_W];
  assign cand_x  = ((rx >= GW) ? rx - GW : rx) + COORD_W'(1);
  assign cand_y  = ((ry >= GH) ? ry - GH : ry) + COORD_W'(1);
  assign trigger = ((game_state == GS_PLAY) && get_food) || (game_state == GS_INIT);

  assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

  always_comb begin
    state_d      = state_q;
    occ_x_d      = occ_x_q;
    occ_y_d      = occ_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    busy_d       = busy_q;
    place_fail_d = 1'b0;
    retry_d      = retry_q;
    if (game_state == GS_OVER) begin
      // Abandon any outstanding query; a late ack lands in IDLE and is ignored.
      state_d      = S_IDLE;
      busy_d       = 1'b0;
      retry_d      = '0;
      food_valid_d = 1'b0;
    end else if (game_state != GS_PAUSE) begin
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            state_d      = S_GEN;
            busy_d       = 1'b1;
            food_valid_d = 1'b0;
            retry_d      = '0;
          end
        end
        S_GEN: begin
          occ_x_d = cand_x;
          occ_y_d = cand_y;
          state_d = S_REQ;
        end
        S_REQ: begin
          if (occ_ack) begin
            if (!occ_hit) begin
              food_x_d     = occ_x_q;
              food_y_d     = occ_y_q;
              food_valid_d = 1'b1;
              busy_d       = 1'b0;
              state_d      = S_IDLE;
            end else if (retry_q < LAST_TRY) begin
              retry_d = retry_q + 8'd1;
              state_d = S_GEN;
            end else begin
              place_fail_d = 1'b1;
              busy_d       = 1'b0;
              state_d      = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      occ_x_q      <= COORD_W'(1);
      occ_y_q      <= COORD_W'(1);
      food_x_q     <= COORD_W'(1);
      food_y_q     <= COORD_W'(1);
      food_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      place_fail_q <= 1'b0;
      retry_q      <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      occ_x_q      <= occ_x_d;
      occ_y_q      <= occ_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      busy_q       <= busy_d;
      place_fail_q <= place_fail_d;
      retry_q      <= retry_d;
    end
  end

  assign occ_req    = (state_q == S_REQ);
  assign occ_x      = occ_x_q;
  assign occ_y      = occ_y_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign busy       = busy_q;
  assign place_fail = place_fail_q;

endmodule

// File: doc/food_gen_param.md
Name: food_gen_param

Overview:
- Parametrised food placer for the snake game, replacing the fixed 30x22 modulo-counter generator.
- Draws pseudo-random candidate cells from a free-running LFSR and folds them into a configurable playfield.
- Checks each candidate against the snake-body occupancy logic through a request/acknowledge handshake, retrying on collision up to a bounded count.
- Sits between the game-state controller, the snake body and the VGA renderer.

Parameters:
- GRID_W, 30, playable columns; food_x range is 1..GRID_W (column 0 is border). Constraint: 2^(COORD_W-1) <= GRID_W <= 2^COORD_W-1.
- GRID_H, 22, playable rows; food_y range is 1..GRID_H. Same constraint as GRID_W.
- COORD_W, 5, coordinate width.
- LFSR_W, 16, LFSR width; must be >= 2*COORD_W.
- LFSR_SEED, 16'hACE1, reset value of the LFSR; must be nonzero.
- MAX_RETRY, 8, maximum collision retries per placement, 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- game_state  in  2  00 PLAY, 01 PAUSE, 10 INIT, 11 OVER
- get_food  in  1  snake head reached the food (level or pulse, sampled on each edge)
- occ_req  out  1  occupancy query valid
- occ_x  out  COORD_W  queried column
- occ_y  out  COORD_W  queried row
- occ_ack  in  1  occupancy response valid; 0 or more cycles after occ_req
- occ_hit  in  1  queried cell holds snake body; qualified by occ_ack
- food_x  out  COORD_W  current food column
- food_y  out  COORD_W  current food row
- food_valid  out  1  food is placed and drawable
- busy  out  1  a placement is in progress
- place_fail  out  1  one-cycle pulse: retries exhausted

Behaviour:
- Reset (async, rst_n=0):
  - food_x=1, food_y=1, food_valid=0, busy=0, occ_req=0, place_fail=0.
  - LFSR=LFSR_SEED, state=IDLE, retry_cnt=0.
- LFSR:
  - Galois, maximal-length taps for LFSR_W; advances on every clk edge in every state.
  - Never reaches zero.
- Candidate mapping:
  - rx = lfsr[COORD_W-1:0] and ry = lfsr[2*COORD_W-1:COORD_W].
  - x = (rx >= GRID_W ? rx-GRID_W : rx) + 1; y is computed the same way against GRID_H.
  - The result is always in range.
- FSM states: IDLE, GEN, REQ.
  - IDLE: a trigger moves to GEN, sets busy=1, clears food_valid and retry_cnt.
    - Trigger = (game_state==PLAY && get_food) OR (game_state==INIT).
    - INIT therefore reshuffles the food continuously.
  - GEN: latch the candidate into the occ_x/occ_y registers, then go to REQ.
  - REQ: occ_req=1 (decoded from state); occ_x/occ_y held stable until occ_ack.
    - On occ_ack && !occ_hit: food_x/food_y <= candidate, food_valid<=1, busy<=0, go to IDLE.
    - On occ_ack && occ_hit && retry_cnt<MAX_RETRY-1: retry_cnt++, go to GEN.
    - On occ_ack && occ_hit && retry_cnt==MAX_RETRY-1: pulse place_fail for one cycle, food_valid stays 0, busy<=0, go to IDLE.
- Latency with a zero-wait responder (ack in the same cycle as req):
  - Trigger sampled at edge t; occ_req high between edges t+1 and t+2.
  - food_valid=1 and new coordinates appear after edge t+2.
  - Each collision retry adds 2 cycles.
- Trigger handling while busy:
  - get_food while busy is ignored; there is no queuing.
  - get_food while food_valid=0 in IDLE still triggers.
- PAUSE (01): the FSM holds its state and outstanding requests stay asserted; food registers hold.
- OVER (11), any state: next edge forces IDLE.
  - occ_req drops, busy=0, retry_cnt=0, food_valid=0.
  - A late occ_ack is ignored; the responder must tolerate an abandoned request.
- Output registers:
  - food_x/food_y change only on successful placement or reset.
  - food_valid falls on the edge after a sampled trigger.
- Reset mid-placement: immediate return to reset values; nothing is committed.

Test Plan:
- Reset then INIT for 1 cycle, zero-wait responder with occ_hit=0 -> occ_req high during the 2nd cycle; food_valid=1 after the 3rd edge; food_x in 1..30, food_y in 1..22; busy back to 0.
- PLAY, get_food pulse, responder returns hit=1 twice then hit=0, ack latency 0 -> exactly 3 occ_req handshakes; food_valid rises 6 cycles after the trigger edge; committed coordinates equal the third query.
- PLAY, get_food, responder always hit=1, MAX_RETRY=8 -> 8 handshakes, one place_fail pulse, food_valid=0, busy=0, FSM returns to IDLE.
- Ack latency 3 cycles with PAUSE asserted mid-wait for 5 cycles -> occ_x/occ_y stable throughout; placement completes after the ack; no extra request is issued.
- OVER asserted while occ_req=1, late ack arrives afterwards -> occ_req low on the next edge; food_valid=0; late ack causes no commit.
- Sweep 10000 placements with GRID_W=17, GRID_H=31, COORD_W=5 -> all coordinates in 1..17 and 1..31; every column and row value hit at least once; LFSR never zero; rst_n asserted mid-REQ returns food_x=1, food_y=1, food_valid=0 asynchronously.
